// File: rtl/matrix_mult_sequencer.sv
// Feeds operand matrices A and B to a combinational matrix multiplier and
// streams the returned result elements out in row-major order.
module matrix_mult_sequencer #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MATRIX_DIMS = 3
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic                                             in_valid,
    output logic                                             in_ready,
    input  logic [WIDTH-1:0]                                 in_data,
    output logic                                             out_valid,
    input  logic                                             out_ready,
    output logic [WIDTH-1:0]                                 out_data,
    output logic                                             out_last,
    output logic                                             busy,
    output logic [MATRIX_DIMS-1:0][MATRIX_DIMS-1:0][WIDTH-1:0] m_a,
    output logic [MATRIX_DIMS-1:0][MATRIX_DIMS-1:0][WIDTH-1:0] m_b,
    output logic [3:0]                                       c_index,
    input  logic [WIDTH-1:0]                                 c_in
);

    localparam int unsigned NN    = MATRIX_DIMS * MATRIX_DIMS;
    localparam int unsigned CNT_W = $clog2(2 * NN);
    localparam int unsigned RC_W  = (MATRIX_DIMS > 1) ? $clog2(MATRIX_DIMS) : 1;

    typedef enum logic [0:0] {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   load_cnt_q, load_cnt_d;
    logic [3:0]         c_index_d;
    logic               out_valid_d, out_last_d;
    logic [WIDTH-1:0]   out_data_d;
    logic               a_we, b_we;
    logic [CNT_W-1:0]   wr_idx;
    logic [RC_W-1:0]    wr_row, wr_col;

    // Word k of either matrix lands at [k/N][k%N]; B words are offset by N*N.
    always_comb begin
        wr_idx = (load_cnt_q >= CNT_W'(NN)) ? (load_cnt_q - CNT_W'(NN)) : load_cnt_q;
        wr_row = RC_W'(wr_idx / CNT_W'(MATRIX_DIMS));
        wr_col = RC_W'(wr_idx % CNT_W'(MATRIX_DIMS));
    end

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        load_cnt_d  = load_cnt_q;
        c_index_d   = c_index;
        out_valid_d = out_valid;
        out_last_d  = out_last;
        out_data_d  = out_data;
        a_we        = 1'b0;
        b_we        = 1'b0;

        case (state_q)
            LOAD: begin
                if (in_valid && in_ready) begin
                    if (load_cnt_q < CNT_W'(NN)) begin
                        a_we = 1'b1;
                    end else begin
                        b_we = 1'b1;
                    end
                    if (load_cnt_q == CNT_W'(2 * NN - 1)) begin
                        state_d    = RUN;
                        load_cnt_d = '0;
                        c_index_d  = '0;
                    end else begin
                        load_cnt_d = load_cnt_q + CNT_W'(1);
                    end
                end
            end
            RUN: begin
                // c_index only moves on a handshake, so c_in is settled by capture.
                if (!out_valid) begin
                    out_data_d  = c_in;
                    out_valid_d = 1'b1;
                    out_last_d  = (c_index == 4'(NN - 1));
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (out_last) begin
                        state_d    = LOAD;
                        c_index_d  = '0;
                        load_cnt_d = '0;
                        out_last_d = 1'b0;
                    end else begin
                        c_index_d = c_index + 4'd1;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= LOAD;
            load_cnt_q <= '0;
            c_index    <= '0;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_data   <= '0;
            m_a        <= '0;
            m_b        <= '0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            c_index    <= c_index_d;
            in_ready   <= (state_d == LOAD);
            busy       <= (state_d == RUN);
            out_valid  <= out_valid_d;
            out_last   <= out_last_d;
            out_data   <= out_data_d;
            if (a_we) begin
                m_a[wr_row][wr_col] <= in_data;
            end
            if (b_we) begin
                m_b[wr_row][wr_col] <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_matrix_mult_sequencer.sv
// Scoreboard bench: stimulus pushes expected products, a negedge monitor checks
// every presented result element against them.
module tb_matrix_mult_sequencer;

    localparam int unsigned W  = 32;
    localparam int unsigned N  = 3;
    localparam int unsigned NN = N * N;

    typedef struct packed {
        logic [W-1:0] data;
        logic [3:0]   idx;
        logic         last;
    } exp_t;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        in_valid;
    logic                        in_ready;
    logic [W-1:0]                in_data;
    logic                        out_valid;
    logic                        out_ready;
    logic [W-1:0]                out_data;
    logic                        out_last;
    logic                        busy;
    logic [N-1:0][N-1:0][W-1:0]  m_a;
    logic [N-1:0][N-1:0][W-1:0]  m_b;
    logic [3:0]                  c_index;
    logic [W-1:0]                c_in;

    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic [W-1:0] ma [NN];
    logic [W-1:0] mb [NN];
    bit   rdy_rand = 1'b1;
    bit   bp_en    = 1'b0;
    bit   bp_done  = 1'b0;

    matrix_mult_sequencer #(.WIDTH(W), .MATRIX_DIMS(N)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy),
        .m_a(m_a), .m_b(m_b), .c_index(c_index), .c_in(c_in)
    );

    always #5 clk = ~clk;

    // Zero-latency multiplier the sequencer drives.
    always_comb begin
        c_in = '0;
        if (c_index < 4'(NN)) begin
            for (int k = 0; k < int'(N); k++) begin
                c_in = c_in + m_a[c_index / 4'(N)][k] * m_b[k][c_index % 4'(N)];
            end
        end
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    // Monitor: compare whatever the DUT presents with the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                mon_e = exp_q[0];
                chk("out_data", out_data, mon_e.data);
                chk("out_last", 32'(out_last), 32'(mon_e.last));
                chk("c_index", 32'(c_index), 32'(mon_e.idx));
                if (out_ready) begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Consumer: random readiness, or a fixed 5-cycle stall on element 4.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bp_en && !bp_done && out_valid && c_index == 4'd4) begin
                out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
                bp_done   = 1'b1;
            end else begin
                out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end
    end

    task automatic push_expected();
        exp_t e;
        logic [W-1:0] acc;
        for (int r = 0; r < int'(N); r++) begin
            for (int c = 0; c < int'(N); c++) begin
                acc = '0;
                for (int k = 0; k < int'(N); k++) begin
                    acc = acc + ma[r * N + k] * mb[k * N + c];
                end
                e.data = acc;
                e.idx  = 4'(r * N + c);
                e.last = (r == int'(N) - 1) && (c == int'(N) - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic send_word(input logic [W-1:0] w, input bit gap);
        in_valid = 1'b1;
        in_data  = w;
        chk("in_ready_load", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (gap) begin
            repeat ($urandom_range(0, 1)) @(posedge clk);
            #1;
        end
    endtask

    task automatic check_matrices(input string tag);
        for (int r = 0; r < int'(N); r++) begin
            for (int c = 0; c < int'(N); c++) begin
                chk({tag, "_m_a"}, m_a[r][c], ma[r * N + c]);
                chk({tag, "_m_b"}, m_b[r][c], mb[r * N + c]);
            end
        end
    endtask

    task automatic run(input bit noise);
        int cyc;
        push_expected();
        for (int k = 0; k < int'(2 * NN); k++) begin
            send_word((k < int'(NN)) ? ma[k] : mb[k - NN], k != int'(2 * NN) - 1);
        end
        @(negedge clk);
        chk("lat_valid_c1", 32'(out_valid), 32'd0);
        chk("busy_run", 32'(busy), 32'd1);
        chk("in_ready_run", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("lat_valid_c2", 32'(out_valid), 32'd1);
        for (cyc = 0; cyc < 400; cyc++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) break;
            if (noise) begin
                chk("in_ready_noise", 32'(in_ready), 32'd0);
                in_valid = 1'b1;
                in_data  = $urandom;
            end
        end
        in_valid = 1'b0;
        if (exp_q.size() != 0) begin
            chk("results_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        @(negedge clk);
        chk("busy_after", 32'(busy), 32'd0);
        chk("in_ready_after", 32'(in_ready), 32'd1);
        check_matrices("hold");
    endtask

    task automatic check_reset_state();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_c_index", 32'(c_index), 32'd0);
        chk("rst_m_a", 32'(|m_a), 32'd0);
        chk("rst_m_b", 32'(|m_b), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Identity times 1..9.
        for (int i = 0; i < int'(NN); i++) begin
            ma[i] = (i % (N + 1) == 0) ? 32'd1 : 32'd0;
            mb[i] = 32'(i + 1);
        end
        run(1'b0);

        // 1..9 times 9..1, random consumer.
        for (int i = 0; i < int'(NN); i++) begin
            ma[i] = 32'(i + 1);
            mb[i] = 32'(NN - i);
        end
        run(1'b0);

        // Same data with a stall on element 4.
        rdy_rand = 1'b0;
        bp_en    = 1'b1;
        bp_done  = 1'b0;
        run(1'b0);
        chk("bp_exercised", 32'(bp_done), 32'd1);
        bp_en    = 1'b0;
        rdy_rand = 1'b1;

        // Truncating accumulation.
        for (int i = 0; i < int'(NN); i++) begin
            ma[i] = 32'hFFFF_FFFF;
            mb[i] = 32'd2;
        end
        run(1'b0);

        // Reset after a partial load, then a fresh full load.
        for (int k = 0; k < 10; k++) begin
            send_word($urandom, 1'b1);
        end
        #2;
        rst = 1'b1;
        #1;
        check_reset_state();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < int'(NN); i++) begin
            ma[i] = $urandom;
            mb[i] = $urandom;
        end
        run(1'b0);

        // Random matrices with in_valid toggling garbage during RUN.
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < int'(NN); i++) begin
                ma[i] = $urandom;
                mb[i] = $urandom;
            end
            run(1'b1);
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
